core_bus_master: RTL and testbench
==================================

# core_bus_master

Bus initiator for the core's shared memory port. Accepts load/readback commands from a host-side stream interface and drives `address`, `wren`, `cpen` and the bidirectional `data` bus exactly as a host would to write words into the core or read them back. It sits between the host loader (UART or JTAG bridge) and the `data`/`address`/`wren`/`cpen` pins of `core`. It releases the bus whenever it is idle.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of the `data` bus and stream words.
- `ADDRESS_WIDTH`, 16: width of the `address` bus.
- `LEN_WIDTH`, 8: width of the burst-length field; a burst moves `cmd_len+1` words.
- `READ_LATENCY`, 1: cycles from read address presented to data valid on `data`; legal range 1..7.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: command accepted this cycle when high together with `cmd_valid`.
- `cmd_write`  in  1: 1 selects a write burst, 0 selects a read burst.
- `cmd_addr`  in  ADDRESS_WIDTH: start address.
- `cmd_len`  in  LEN_WIDTH: word count minus 1.
- `wr_valid`, `wr_ready`  in, out  1: write-data stream handshake.
- `wr_data`  in  DATA_WIDTH: write word.
- `rd_valid`, `rd_ready`  out, in  1: read-data stream handshake.
- `rd_data`  out  DATA_WIDTH: read word.
- `busy`  out  1: high whenever the state is not IDLE.
- `address`  out  ADDRESS_WIDTH: core memory address.
- `data`  inout  DATA_WIDTH: shared data bus; driven only while `wren & cpen`, otherwise high-Z.
- `wren`  out  1: write enable to the core.
- `cpen`  out  1: core port enable.

## Operation
- States are IDLE, WR, RD_REQ, RD_WAIT and RD_OUT.
- **IDLE:** `cmd_ready=1`. On `cmd_valid`, latch `cmd_addr` into the address register and `cmd_len` into the remaining counter. Go to WR if `cmd_write`, otherwise go to RD_REQ.
- **WR:**
  - `wr_ready=1`.
  - In each cycle with `wr_valid`, the block drives `cpen=1`, `wren=1`, `data=wr_data` and `address`. The word is written at that edge.
  - After each written word, the address increments and the remaining counter decrements.
  - When `wr_valid=0`, `cpen=wren=0`, `data` is high-Z and the address holds.
  - After the last word, return to IDLE.
- **RD_REQ:** `cpen=1`, `wren=0`, `address` is presented. Load the latency counter with `READ_LATENCY-1` and go to RD_WAIT.
- **RD_WAIT:**
  - `cpen=1` and `address` is held.
  - When the counter reaches 0, sample `data` into `rd_data` and go to RD_OUT.
  - Otherwise decrement the counter.
- **RD_OUT:**
  - `rd_valid=1` and `cpen=0`.
  - On `rd_ready`: increment the address and decrement the remaining counter.
  - Then go to RD_REQ if words remain, otherwise go to IDLE.
- **Address arithmetic:** modulo 2^ADDRESS_WIDTH, so 0xFFFF+1 wraps to 0x0000. The remaining counter is LEN_WIDTH+1 bits wide.
- **Bus turnaround:** every command boundary passes through IDLE, so at least one undriven cycle separates a write from the next read.
- **Commands in flight:** `cmd_valid` while busy is ignored (`cmd_ready=0`); commands are never queued.

## Timing
- **Reset values:** state IDLE, `cmd_ready=1`, `wr_ready=0`, `rd_valid=0`, `rd_data=0`, `busy=0`, `address=0`, `wren=0`, `cpen=0`, `data` high-Z.
- **Reset mid-burst:** the bus is released immediately (asynchronously). Remaining words are dropped and no partial-state flag is kept.
- **Write throughput:** 1 word/cycle with `wr_valid` held high. Command to first write is 1 cycle (accept edge, then WR).
- **Read throughput:** 1 word per `READ_LATENCY+2` cycles when `rd_ready` is held high.
- **Output registers:** `wren`, `cpen` and `address` are combinational from state and registers. `rd_data` is registered and holds its value while `rd_valid & !rd_ready`.
- **Stalls:** `wr_valid` and `rd_ready` may toggle on any cycle. A stall never advances the address.

## Configuration
- Macro: `CORE_BUS_MASTER_BURST_EN`.
- **Defined:** `cmd_len` is honoured and bursts move `cmd_len+1` words.
- **Undefined:**
  - `cmd_len` is ignored and every command moves exactly one word.
  - The remaining counter and its logic are removed.
  - All interface ports are retained.

## Structure
- **Shared package `core_bus_pkg`:**
  - state enum `bus_state_t` (IDLE, WR, RD_REQ, RD_WAIT, RD_OUT);
  - `CORE_DATA_WIDTH=16` and `CORE_ADDRESS_WIDTH=16`, shared with `core`.
- **Sub-module `core_bus_driver`:** the tristate pad. It drives `data` from `wr_data` when `wren & cpen`, else high-Z, and returns the bus value for sampling. It keeps the inout away from the FSM.

## Test plan
- Write burst: cmd(write, addr=0x0000, len=1) with stream words 0x4000, 0x01C0 -> `wren=cpen=1` on two consecutive cycles at addresses 0x0000 and 0x0001; the core model holds those values; `busy` drops the next cycle.
- Readback: cmd(read, addr=0x0000, len=1) after the write -> `rd_data` 0x4000 then 0x01C0; `data` is never driven by the master while `wren=0`.
- Stall: write len=3 with `wr_valid` low on cycle 2 -> `cpen=0` that cycle; the address holds at 0x0011 (start 0x0010); all 4 words land at 0x0010..0x0013.
- Wrap: write addr=0xFFFF, len=1 -> words land at 0xFFFF and 0x0000.
- Read backpressure: `rd_ready` held low for 5 cycles -> `rd_valid` and `rd_data` stay stable; the address does not advance; no extra read strobe is issued.
- Reset mid-burst: assert `rst_n=0` during WR of len=7 after 3 words -> `data` is high-Z and `wren=cpen=0` immediately; after release, `cmd_ready=1` and `address=0`.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared definitions for the core memory port: bus FSM states and the core's
// native data/address widths.
package core_bus_pkg;

    localparam int CORE_DATA_WIDTH    = 16;
    localparam int CORE_ADDRESS_WIDTH = 16;
    localparam int LAT_CNT_WIDTH      = 3;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } bus_state_t;

endpackage

// File: rtl/core_bus_driver.sv
// Tristate pad for the shared core data bus: drives write data only during a
// write strobe and hands the resolved bus value back for read sampling.
module core_bus_driver
    import core_bus_pkg::*;
#(
    parameter int DATA_WIDTH = CORE_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wren_i,
    input  logic                  cpen_i,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] bus_o
);

    assign data  = (wren_i && cpen_i) ? wr_data_i : {DATA_WIDTH{1'bz}};
    assign bus_o = data;

endmodule

// File: rtl/core_bus_master.sv
// Host-side bus initiator for the core memory port. Burst support is enabled by
// defining CORE_BUS_MASTER_BURST_EN; otherwise every command moves one word.
module core_bus_master
    import core_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = CORE_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = CORE_ADDRESS_WIDTH,
    parameter int LEN_WIDTH     = 8,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0]    data,
    output logic                     wren,
    output logic                     cpen
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_INIT = LAT_CNT_WIDTH'(READ_LATENCY - 1);

    bus_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LAT_CNT_WIDTH-1:0] lat_q, lat_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]    bus_in;
    logic                     rem_load;
    logic                     rem_dec;
    logic                     last_word;

    core_bus_driver #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_driver (
        .wr_data_i (wr_data),
        .wren_i    (wren),
        .cpen_i    (cpen),
        .data      (data),
        .bus_o     (bus_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lat_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef CORE_BUS_MASTER_BURST_EN
    logic [LEN_WIDTH:0] rem_q, rem_d;

    always_comb begin
        rem_d = rem_q;
        if (rem_load) begin
            rem_d = {1'b0, cmd_len};
        end else if (rem_dec) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign last_word = (rem_q == '0);
`else
    // Single-word mode: the length field and counter controls have no consumer.
    logic len_unused;
    assign len_unused = ^{cmd_len, rem_load, rem_dec};
    assign last_word  = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lat_d     = lat_q;
        rd_data_d = rd_data_q;
        rem_load  = 1'b0;
        rem_dec   = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        wren      = 1'b0;
        cpen      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    rem_load = 1'b1;
                    state_d  = cmd_write ? WR : RD_REQ;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                // A stalled cycle leaves the bus undriven and the address parked.
                if (wr_valid) begin
                    cpen    = 1'b1;
                    wren    = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    rem_dec = 1'b1;
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_REQ: begin
                cpen    = 1'b1;
                lat_d   = LAT_INIT;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                cpen = 1'b1;
                if (lat_q == '0) begin
                    rd_data_d = bus_in;
                    state_d   = RD_OUT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    addr_d  = addr_q + 1'b1;
                    rem_dec = 1'b1;
                    state_d = last_word ? IDLE : RD_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign address = addr_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_core_bus_master.sv
// Bench for core_bus_master: a behavioural core memory on the bus plus a
// word-level reference memory, driven by directed and randomized commands.
module tb_core_bus_master;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam int RL = 1;
`ifdef CORE_BUS_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] address;
    wire  [DW-1:0] data;
    logic          wren, cpen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_bus_master #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .LEN_WIDTH     (LW),
        .READ_LATENCY  (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .cpen      (cpen)
    );

    // Core memory: writes on wren&cpen, read data appears RL cycles after the address.
    logic [DW-1:0] core_mem [0:65535];
    logic [DW-1:0] q_sh [0:7];
    logic          v_sh [0:7];

    always @(posedge clk) begin
        if (cpen && wren) core_mem[address] <= data;
        q_sh[0] <= core_mem[address];
        v_sh[0] <= cpen && !wren && rst_n;
        for (int i = 1; i < 8; i++) begin
            q_sh[i] <= q_sh[i-1];
            v_sh[i] <= v_sh[i-1] && rst_n;
        end
    end

    assign data = v_sh[RL-1] ? q_sh[RL-1] : {DW{1'bz}};

    // Reference: what each address should hold from the host's point of view.
    logic [DW-1:0] ref_mem [0:65535];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spurious_cmd();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 16'($urandom);
        cmd_len   = 8'($urandom);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] len,
                            input logic [31:0] stall_mask, input bit rand_stall,
                            input bit use_fixed, input logic [31:0] fixed);
        int n = BURST ? int'(len) + 1 : 1;
        logic [15:0] ea = a;
        logic [15:0] w;
        int done = 0;
        int cyc = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
        wr_valid = 1'b0;
        #1;
        check("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("wr_idle_busy", 32'(busy), 32'd0);
        while (done < n && cyc < 300) begin
            @(negedge clk);
            spurious_cmd();
            w = 16'($urandom);
            if (use_fixed) w = (done == 0) ? fixed[31:16] : fixed[15:0];
            wr_valid = !((cyc < 32 && stall_mask[cyc % 32]) ||
                         (rand_stall && $urandom_range(0, 3) == 0));
            wr_data = w;
            #1;
            check("wr_busy", 32'(busy), 32'd1);
            check("wr_cmd_blocked", 32'(cmd_ready), 32'd0);
            check("wr_ready", 32'(wr_ready), 32'd1);
            check("wr_cpen", 32'(cpen), 32'(wr_valid));
            check("wr_wren", 32'(wren), 32'(wr_valid));
            check("wr_addr", 32'(address), 32'(ea));
            check("wr_rd_valid", 32'(rd_valid), 32'd0);
            if (wr_valid) check("wr_bus", 32'(data), 32'(w));
            @(posedge clk);
            if (wr_valid) begin
                ref_mem[ea] = w;
                ea = ea + 16'd1;
                done++;
            end
            cyc++;
        end
        check("wr_words_done", 32'(done), 32'(n));
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b0;
        #1;
        check("wr_end_busy", 32'(busy), 32'd0);
        check("wr_end_ready", 32'(cmd_ready), 32'd1);
        check("wr_end_addr", 32'(address), 32'(ea));
        check("wr_end_cpen", 32'(cpen), 32'd0);
        for (int i = 0; i < n; i++) begin
            logic [15:0] x;
            x = a + 16'(i);
            check("wr_core_mem", 32'(core_mem[x]), 32'(ref_mem[x]));
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] len,
                           input int stall0, input bit rand_stall);
        int n = BURST ? int'(len) + 1 : 1;
        logic [15:0] ea = a;
        int stall;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
        rd_ready = 1'b0;
        #1;
        check("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int wd = 0; wd < n; wd++) begin
            @(negedge clk);
            spurious_cmd();
            rd_ready = 1'($urandom_range(0, 1));
            #1;
            check("rd_req_cpen", 32'(cpen), 32'd1);
            check("rd_req_wren", 32'(wren), 32'd0);
            check("rd_req_addr", 32'(address), 32'(ea));
            check("rd_req_valid", 32'(rd_valid), 32'd0);
            check("rd_req_busy", 32'(busy), 32'd1);
            check("rd_cmd_blocked", 32'(cmd_ready), 32'd0);
            for (int k = 0; k < RL; k++) begin
                @(negedge clk);
                #1;
                check("rd_wait_cpen", 32'(cpen), 32'd1);
                check("rd_wait_wren", 32'(wren), 32'd0);
                check("rd_wait_addr", 32'(address), 32'(ea));
                check("rd_wait_valid", 32'(rd_valid), 32'd0);
            end
            stall = (wd == 0) ? stall0 : (rand_stall ? int'($urandom_range(0, 3)) : 0);
            for (int k = 0; k <= stall; k++) begin
                @(negedge clk);
                rd_ready = (k == stall);
                #1;
                check("rd_out_valid", 32'(rd_valid), 32'd1);
                check("rd_out_cpen", 32'(cpen), 32'd0);
                check("rd_out_wren", 32'(wren), 32'd0);
                check("rd_out_data", 32'(rd_data), 32'(ref_mem[ea]));
                check("rd_out_addr", 32'(address), 32'(ea));
            end
            ea = ea + 16'd1;
        end
        @(negedge clk);
        cmd_valid = 1'b0; rd_ready = 1'b0;
        #1;
        check("rd_end_busy", 32'(busy), 32'd0);
        check("rd_end_ready", 32'(cmd_ready), 32'd1);
        check("rd_end_addr", 32'(address), 32'(ea));
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({phase, "_wr_ready"}, 32'(wr_ready), 32'd0);
        check({phase, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({phase, "_rd_data"}, 32'(rd_data), 32'd0);
        check({phase, "_busy"}, 32'(busy), 32'd0);
        check({phase, "_address"}, 32'(address), 32'd0);
        check({phase, "_wren"}, 32'(wren), 32'd0);
        check({phase, "_cpen"}, 32'(cpen), 32'd0);
    endtask

    initial begin
        logic [15:0] ea;
        logic [15:0] a;
        logic [7:0]  len;
        int          k;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check_reset_outputs("post_rst");

        // Write burst then readback of the two reference words
        do_write(16'h0000, 8'd1, 32'h0, 1'b0, 1'b1, 32'h4000_01C0);
        do_read(16'h0000, 8'd1, 0, 1'b0);

        // Write with a stall on the second WR cycle, then read with 5 cycles of backpressure
        do_write(16'h0010, 8'd3, 32'h2, 1'b0, 1'b0, 32'h0);
        do_read(16'h0010, 8'd3, 5, 1'b0);

        // Address wrap
        do_write(16'hFFFF, 8'd1, 32'h0, 1'b0, 1'b0, 32'h0);
        do_read(16'hFFFF, 8'd1, 0, 1'b0);

        // Randomized commands, stalls and backpressure
        for (int it = 0; it < 8; it++) begin
            a   = 16'($urandom);
            len = 8'($urandom_range(0, 4));
            do_write(a, len, 32'h0, 1'b1, 1'b0, 32'h0);
            do_read(a, len, int'($urandom_range(0, 2)), 1'b1);
        end

        // Reset in the middle of a write burst
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_len = 8'd7;
        #1;
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        ea = 16'h0040;
        k  = BURST ? 3 : 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'($urandom);
            #1;
            check("mid_wren", 32'(wren), 32'd1);
            @(posedge clk);
            ref_mem[ea] = wr_data;
            ea = ea + 16'd1;
        end
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'($urandom);
        #1;
        check("mid_pre_rst_wren", 32'(wren), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; wr_valid = 1'b0;
        #1;
        check_reset_outputs("mid_release");
        for (int i = 0; i < k; i++) begin
            logic [15:0] x;
            x = 16'h0040 + 16'(i);
            check("mid_core_mem", 32'(core_mem[x]), 32'(ref_mem[x]));
        end

        // Recovery after reset
        do_write(16'h1234, 8'd2, 32'h0, 1'b1, 1'b0, 32'h0);
        do_read(16'h1234, 8'd2, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
